instr_encoder: RTL

- Encoder counterpart of the single-cycle control decoder: turns structured instruction commands (kind, rs, rt, rd, imm) into 32-bit MIPS words.
- Streams the words into instruction memory at consecutive word addresses.
- Used by the program loader and by benches to build test programs for the decoder/datapath.
- Command side uses a valid/ready handshake, buffered by a small FIFO; memory side has a registered write port with back-pressure.

---
 rtl/instr_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes structured commands into 32-bit MIPS words and streams them to imem
//
// Buffers commands in a DEPTH-entry FIFO and writes one word per cycle at consecutive
// word addresses, starting from BASE_ADDR.
// Optional build macro: ZERO_DST_NOP_EN (legal instructions targeting $0 become NOP; sw never).
// Ports:
//   clk, rst (async, active-high), clear (sync flush of FIFO, address and counters)
//   cmd_valid/cmd_ready handshake; cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm command fields
//   imem_ready back-pressure; imem_we, imem_addr, imem_wdata registered write port
//   word_cnt words written (saturating); err sticky illegal kind; wrapped sticky address wrap
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic              imem_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              err,
    output logic              wrapped
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]       r_fifo [DEPTH];
    logic [PW-1:0]     r_wr, r_rd;
    logic [PW:0]       r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [31:0]       w_word;
    logic [5:0]        w_op, w_funct;
    logic              w_rtype, w_legal, w_acc, w_push, w_pop;

    always_comb begin
        w_rtype = cmd_kind <= 4'd5;
        w_legal = cmd_kind <= 4'd12;
        w_funct = 6'h20;
        w_op    = 6'h00;
        case (cmd_kind)
            4'd1:    w_funct = 6'h21;
            4'd2:    w_funct = 6'h23;
            4'd3:    w_funct = 6'h24;
            4'd4:    w_funct = 6'h25;
            4'd5:    w_funct = 6'h2A;
            4'd6:    w_op    = 6'h08;
            4'd7:    w_op    = 6'h09;
            4'd8:    w_op    = 6'h0C;
            4'd9:    w_op    = 6'h0D;
            4'd10:   w_op    = 6'h0F;
            4'd11:   w_op    = 6'h2B;
            4'd12:   w_op    = 6'h23;
            default: w_funct = 6'h20;
        endcase
        // lui has no source register, so its rs field is forced to zero
        w_word = w_rtype ? {6'b0, cmd_rs, cmd_rt, cmd_rd, 5'b0, w_funct}
                         : {w_op, (cmd_kind == 4'd10) ? 5'd0 : cmd_rs, cmd_rt, cmd_imm};
`ifdef ZERO_DST_NOP_EN
        // a write to $0 has no architectural effect; sw has no destination at all
        if (w_rtype ? (cmd_rd == 5'd0) : (cmd_kind != 4'd11 && cmd_rt == 5'd0))
            w_word = 32'h0;
`endif
    end

    assign cmd_ready = r_cnt != (PW+1)'(DEPTH);
    assign w_acc     = cmd_valid && cmd_ready;
    assign w_push    = w_acc && w_legal && !clear;
    assign w_pop     = (r_cnt != '0) && imem_ready && !clear;

    // storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr] <= w_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_ptr      <= ADDR_W'(BASE_ADDR);
            imem_we    <= 1'b0;
            imem_addr  <= ADDR_W'(BASE_ADDR);
            imem_wdata <= 32'h0;
            word_cnt   <= '0;
            err        <= 1'b0;
            wrapped    <= 1'b0;
        end else if (clear) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_ptr    <= ADDR_W'(BASE_ADDR);
            imem_we  <= 1'b0;
            word_cnt <= '0;
            err      <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            imem_we <= w_pop;
            r_cnt   <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_push)
                r_wr <= r_wr + PW'(1);
            if (w_acc && !w_legal)
                err <= 1'b1;
            if (w_pop) begin
                r_rd       <= r_rd + PW'(1);
                imem_wdata <= r_fifo[r_rd];
                imem_addr  <= r_ptr;
                r_ptr      <= r_ptr + ADDR_W'(1);
                if (word_cnt != '1)
                    word_cnt <= word_cnt + (ADDR_W+1)'(1);
                if (r_ptr == '1)
                    wrapped <= 1'b1;
            end
        end
    end
endmodule
